// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-register types: skid state encoding, mem control bit positions, EX/MEM payload
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;
    localparam int WB_W_DEF   = 2;
    localparam int LB_W_DEF   = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skidState_e;

    // Bit positions inside the {lbsel, memwrite, memread, branch} mem control field
    localparam int MEM_BRANCH = 0;
    localparam int MEM_READ   = 1;
    localparam int MEM_WRITE  = 2;
    localparam int MEM_LBSEL  = 3;

    typedef struct packed {
        logic [WB_W_DEF-1:0]   wb;
        logic [LB_W_DEF-1:0]   lbsel;
        logic                  memwrite;
        logic                  memread;
        logic                  branch;
        logic [DATA_W_DEF-1:0] pcAdd;
        logic                  zero;
        logic [DATA_W_DEF-1:0] alu;
        logic [DATA_W_DEF-1:0] rd2;
        logic [REG_W_DEF-1:0]  regDst;
    } exMemPayload_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// rtl/ex_mem_stage_if.sv - Execute-side and Memory-side handshake/payload bundle of the EX/MEM register
interface ex_mem_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int WB_W   = 2,
    parameter int LB_W   = 2
);
    logic              flush;
    logic              e_valid;
    logic              e_ready;
    logic [WB_W-1:0]   wb_e;
    logic [LB_W+2:0]   mem_e;
    logic [DATA_W-1:0] pc_add_e;
    logic              zero_e;
    logic [DATA_W-1:0] alu_e;
    logic [DATA_W-1:0] rd2_e;
    logic [REG_W-1:0]  regdst_e;

    logic              m_valid;
    logic              m_ready;
    logic [WB_W-1:0]   wb_m;
    logic [LB_W-1:0]   lbsel_m;
    logic              memwrite_m;
    logic              memread_m;
    logic              branch_m;
    logic [DATA_W-1:0] pc_add_m;
    logic [DATA_W-1:0] alu_m;
    logic [DATA_W-1:0] rd2_m;
    logic              zero_m;
    logic [REG_W-1:0]  regdst_m;
    logic [1:0]        occ;

    modport slave (
        input  flush, e_valid, wb_e, mem_e, pc_add_e, zero_e, alu_e, rd2_e, regdst_e, m_ready,
        output e_ready, m_valid, wb_m, lbsel_m, memwrite_m, memread_m, branch_m,
               pc_add_m, alu_m, rd2_m, zero_m, regdst_m, occ
    );

    modport master (
        output flush, e_valid, wb_e, mem_e, pc_add_e, zero_e, alu_e, rd2_e, regdst_e, m_ready,
        input  e_ready, m_valid, wb_m, lbsel_m, memwrite_m, memread_m, branch_m,
               pc_add_m, alu_m, rd2_m, zero_m, regdst_m, occ
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - generic 2-entry skid buffer; ready depends on registered state only
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         inValid,
    output logic         inReady,
    input  logic [W-1:0] inData,
    output logic         outValid,
    input  logic         outReady,
    output logic [W-1:0] outData,
    output logic [1:0]   occ
);
    skidState_e   state, stateNext;
    logic [W-1:0] mainQ, skidQ;
    logic         loadMainIn, loadMainSkid, loadSkid;
    logic         inFire, outFire;

    assign inReady  = (state != FULL);
    assign outValid = (state != EMPTY);
    assign outData  = mainQ;
    assign occ      = state;
    assign inFire   = inValid & inReady;
    assign outFire  = outValid & outReady;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= EMPTY;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext    = state;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        case (state)
            EMPTY: if (inFire) begin
                stateNext  = ONE;
                loadMainIn = 1'b1;
            end
            ONE: begin
                if (inFire && outFire) begin
                    loadMainIn = 1'b1;
                end else if (inFire) begin
                    stateNext = FULL;
                    loadSkid  = 1'b1;
                end else if (outFire) begin
                    stateNext = EMPTY;
                end
            end
            FULL: if (outFire) begin
                stateNext    = ONE;
                loadMainSkid = 1'b1;
            end
            default: stateNext = EMPTY;
        endcase
        // A redirect kills everything held and whatever arrives alongside it
        if (flush) begin
            stateNext    = EMPTY;
            loadMainIn   = 1'b0;
            loadMainSkid = 1'b0;
            loadSkid     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mainQ <= '0;
            skidQ <= '0;
        end else begin
            if (loadMainIn)        mainQ <= inData;
            else if (loadMainSkid) mainQ <= skidQ;
            if (loadSkid)          skidQ <= inData;
        end
    end
endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - elastic EX->MEM pipeline register with flush and bubble-gated control outputs
module ex_mem_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int WB_W   = WB_W_DEF,
    parameter int LB_W   = LB_W_DEF
) (
    input logic            clk,
    input logic            rst,
    ex_mem_stage_if.slave  bus
);
    localparam int MEM_W = LB_W + 3;
    localparam int PW    = WB_W + MEM_W + DATA_W + 1 + DATA_W + DATA_W + REG_W;

    logic [PW-1:0]     inData, outData;
    logic              headValid;
    logic [WB_W-1:0]   wbQ;
    logic [MEM_W-1:0]  memQ;
    logic [DATA_W-1:0] pcQ, aluQ, rd2Q;
    logic              zeroQ;
    logic [REG_W-1:0]  rdQ;

    assign inData = {bus.wb_e, bus.mem_e, bus.pc_add_e, bus.zero_e, bus.alu_e, bus.rd2_e, bus.regdst_e};

    pipe_skid_reg #(.W(PW)) uSkid (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.flush),
        .inValid  (bus.e_valid),
        .inReady  (bus.e_ready),
        .inData   (inData),
        .outValid (headValid),
        .outReady (bus.m_ready),
        .outData  (outData),
        .occ      (bus.occ)
    );

    assign {wbQ, memQ, pcQ, zeroQ, aluQ, rd2Q, rdQ} = outData;

    assign bus.m_valid  = headValid;
    assign bus.pc_add_m = pcQ;
    assign bus.alu_m    = aluQ;
    assign bus.rd2_m    = rd2Q;
    assign bus.zero_m   = zeroQ;
    assign bus.regdst_m = rdQ;
    assign bus.lbsel_m  = memQ[MEM_LBSEL +: LB_W];

    // Side-effecting controls must read as a bubble whenever the head is stale
    assign bus.wb_m       = headValid ? wbQ : '0;
    assign bus.memwrite_m = headValid & memQ[MEM_WRITE];
    assign bus.memread_m  = headValid & memQ[MEM_READ];
    assign bus.branch_m   = headValid & memQ[MEM_BRANCH];
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - self-checking bench for ex_mem_stage
module tb_ex_mem_stage;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ex_mem_stage_if #(.DATA_W(32), .REG_W(5), .WB_W(2), .LB_W(2)) bus ();

    ex_mem_stage #(.DATA_W(32), .REG_W(5), .WB_W(2), .LB_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  mem;
        logic [1:0]  wb;
        logic        expWr;
        logic        expRd;
        logic        expBr;
        logic [1:0]  expLb;
    } vec_t;

    vec_t          vecs[8];
    exMemPayload_t sbQ[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic exMemPayload_t expFromInputs();
        exMemPayload_t p;
        p.wb       = bus.wb_e;
        p.lbsel    = {bus.mem_e[4], bus.mem_e[3]};
        p.memwrite = bus.mem_e[2];
        p.memread  = bus.mem_e[1];
        p.branch   = bus.mem_e[0];
        p.pcAdd    = bus.pc_add_e;
        p.zero     = bus.zero_e;
        p.alu      = bus.alu_e;
        p.rd2      = bus.rd2_e;
        p.regDst   = bus.regdst_e;
        return p;
    endfunction

    function automatic exMemPayload_t actFromOutputs();
        exMemPayload_t p;
        p.wb       = bus.wb_m;
        p.lbsel    = bus.lbsel_m;
        p.memwrite = bus.memwrite_m;
        p.memread  = bus.memread_m;
        p.branch   = bus.branch_m;
        p.pcAdd    = bus.pc_add_m;
        p.zero     = bus.zero_m;
        p.alu      = bus.alu_m;
        p.rd2      = bus.rd2_m;
        p.regDst   = bus.regdst_m;
        return p;
    endfunction

    // Scoreboard: inputs are stable from #1 after posedge, so negedge values are what the next edge sees
    always @(negedge clk) begin
        if (!rst) begin
            sbQ.delete();
        end else begin
            if (bus.m_valid && bus.m_ready) begin
                if (sbQ.size() == 0) begin
                    check("sb_unexpected_output", 128'(sbQ.size()), 128'd1);
                end else begin
                    check("sb_payload", 128'(actFromOutputs()), 128'(sbQ.pop_front()));
                end
            end
            if (bus.flush) sbQ.delete();
            else if (bus.e_valid && bus.e_ready) sbQ.push_back(expFromInputs());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] alu, input logic [4:0] mem, input logic [1:0] wb);
        bus.e_valid  = 1'b1;
        bus.alu_e    = alu;
        bus.mem_e    = mem;
        bus.wb_e     = wb;
        bus.pc_add_e = $urandom;
        bus.rd2_e    = $urandom;
        bus.regdst_e = 5'($urandom);
        bus.zero_e   = 1'($urandom);
    endtask

    initial begin
        vecs[0] = '{32'd1, 5'b00000, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[1] = '{32'd2, 5'b00001, 2'b01, 1'b0, 1'b0, 1'b1, 2'd0};
        vecs[2] = '{32'd3, 5'b00010, 2'b10, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[3] = '{32'd4, 5'b00100, 2'b11, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[4] = '{32'd5, 5'b01000, 2'b00, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[5] = '{32'd6, 5'b10110, 2'b01, 1'b1, 1'b1, 1'b0, 2'd2};
        vecs[6] = '{32'd7, 5'b11111, 2'b10, 1'b1, 1'b1, 1'b1, 2'd3};
        vecs[7] = '{32'd8, 5'b11001, 2'b11, 1'b0, 1'b0, 1'b1, 2'd3};

        bus.flush   = 1'b0;
        bus.m_ready = 1'b0;
        drive(32'hDEAD, 5'b11111, 2'b11);

        // Reset held for two edges with e_valid=1
        tick();
        tick();
        check("rst_m_valid", 128'(bus.m_valid), 128'd0);
        check("rst_e_ready", 128'(bus.e_ready), 128'd1);
        check("rst_occ", 128'(bus.occ), 128'd0);
        check("rst_outputs", 128'(actFromOutputs()), 128'd0);

        rst = 1'b1;
        drive(32'h1234, 5'b00000, 2'b01);
        tick();
        bus.e_valid = 1'b0;
        check("first_m_valid", 128'(bus.m_valid), 128'd1);
        check("first_alu_m", 128'(bus.alu_m), 128'h1234);
        bus.m_ready = 1'b1;
        tick();
        check("first_drain_occ", 128'(bus.occ), 128'd0);

        // Streaming at one entry per cycle
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].alu, vecs[i].mem, vecs[i].wb);
            tick();
            check($sformatf("stream%0d_alu", i), 128'(bus.alu_m), 128'(vecs[i].alu));
            check($sformatf("stream%0d_ctrl", i),
                  128'({bus.wb_m, bus.memwrite_m, bus.memread_m, bus.branch_m, bus.lbsel_m}),
                  128'({vecs[i].wb, vecs[i].expWr, vecs[i].expRd, vecs[i].expBr, vecs[i].expLb}));
            check($sformatf("stream%0d_occ", i), 128'(bus.occ), 128'd1);
            check($sformatf("stream%0d_e_ready", i), 128'(bus.e_ready), 128'd1);
        end
        bus.e_valid = 1'b0;
        tick();
        check("stream_end_m_valid", 128'(bus.m_valid), 128'd0);

        // Backpressure: A, B fill the stage, C waits at the input
        bus.m_ready = 1'b0;
        drive(32'hA, 5'b00000, 2'b00);
        tick();
        check("bp_occ1", 128'(bus.occ), 128'd1);
        drive(32'hB, 5'b00000, 2'b00);
        tick();
        check("bp_occ2", 128'(bus.occ), 128'd2);
        check("bp_e_ready_low", 128'(bus.e_ready), 128'd0);
        drive(32'hC, 5'b00000, 2'b00);
        tick();
        check("bp_hold_occ", 128'(bus.occ), 128'd2);
        check("bp_head_A", 128'(bus.alu_m), 128'hA);
        bus.m_ready = 1'b1;
        tick();
        check("bp_head_B", 128'(bus.alu_m), 128'hB);
        check("bp_e_ready_back", 128'(bus.e_ready), 128'd1);
        tick();
        bus.e_valid = 1'b0;
        check("bp_head_C", 128'(bus.alu_m), 128'hC);
        check("bp_occ_C", 128'(bus.occ), 128'd1);
        tick();
        check("bp_drained", 128'(bus.occ), 128'd0);

        // Flush while FULL with a concurrent input
        bus.m_ready = 1'b0;
        drive(32'h21, 5'b00100, 2'b11);
        tick();
        drive(32'h22, 5'b00100, 2'b11);
        tick();
        check("fl_full", 128'(bus.occ), 128'd2);
        drive(32'h99, 5'b00100, 2'b11);
        bus.flush = 1'b1;
        tick();
        bus.flush   = 1'b0;
        bus.e_valid = 1'b0;
        check("fl_occ", 128'(bus.occ), 128'd0);
        check("fl_m_valid", 128'(bus.m_valid), 128'd0);
        check("fl_gated", 128'({bus.memwrite_m, bus.wb_m}), 128'd0);
        bus.m_ready = 1'b1;
        tick();
        check("fl_input_dropped", 128'(bus.m_valid), 128'd0);

        // Flush in ONE with an accept-able input: the input must also vanish
        bus.m_ready = 1'b0;
        drive(32'h31, 5'b00000, 2'b01);
        tick();
        drive(32'h32, 5'b00100, 2'b01);
        bus.flush = 1'b1;
        tick();
        bus.flush   = 1'b0;
        bus.e_valid = 1'b0;
        check("fl1_occ", 128'(bus.occ), 128'd0);
        check("fl1_e_ready", 128'(bus.e_ready), 128'd1);

        // Bubble gating after a single load/store entry
        bus.m_ready = 1'b1;
        drive(32'h55, 5'b00110, 2'b11);
        tick();
        bus.e_valid = 1'b0;
        check("bub_active", 128'({bus.memwrite_m, bus.memread_m, bus.wb_m}), 128'b1111);
        tick();
        check("bub_gated", 128'({bus.m_valid, bus.memwrite_m, bus.memread_m, bus.wb_m}), 128'd0);

        // Asynchronous reset between edges while FULL
        bus.m_ready = 1'b0;
        drive(32'h71, 5'b00110, 2'b10);
        tick();
        drive(32'h72, 5'b00110, 2'b10);
        tick();
        bus.e_valid = 1'b0;
        check("ar_full", 128'(bus.occ), 128'd2);
        #2 rst = 1'b0;
        #1;
        check("ar_m_valid", 128'(bus.m_valid), 128'd0);
        check("ar_occ", 128'(bus.occ), 128'd0);
        check("ar_e_ready", 128'(bus.e_ready), 128'd1);
        tick();
        rst = 1'b1;
        tick();
        check("ar_after_release", 128'(bus.m_valid), 128'd0);
        check("sb_empty_end", 128'(sbQ.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
